// File: rtl/dmem_if.sv
// Request/acknowledge bus between the memory stage and a variable-latency data memory.
// The memory stage drives it through the master modport; the memory side uses the slave modport.
interface dmem_if;
  logic        req;
  logic        we;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic [63:0] rdata;
  logic        ack;
  logic        err;

  modport master (output req, we, addr, wdata, input rdata, ack, err);
  modport slave  (input req, we, addr, wdata, output rdata, ack, err);
endinterface

// File: rtl/mem_stage.sv
// Y86-64 memory stage: performs the quadword access for the instruction in M over the dmem bus.
// While the access is outstanding it asserts o_m_stall, and it reports the result to W.
module mem_stage #(
  parameter int unsigned MEM_BYTES = 8192,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  i_M_stat,
  input  logic [3:0]  i_M_icode,
  input  logic [63:0] i_M_valE,
  input  logic [63:0] i_M_valA,
  input  logic [3:0]  i_M_dstE,
  input  logic [3:0]  i_M_dstM,
  dmem_if.master      dmem,
  output logic        o_m_stall,
  output logic [1:0]  o_m_stat,
  output logic [3:0]  o_m_icode,
  output logic [63:0] o_m_valE,
  output logic [63:0] o_m_valM,
  output logic [3:0]  o_m_dstE,
  output logic [3:0]  o_m_dstM
);
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  localparam int          CW       = $clog2(TIMEOUT + 1);
  localparam logic [63:0] MAX_ADDR = 64'(MEM_BYTES) - 64'd8;
  localparam logic [1:0]  STAT_AOK = 2'd0;
  localparam logic [1:0]  STAT_ADR = 2'd2;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_req;
  logic          r_we;
  logic [63:0]   r_addr;
  logic [63:0]   r_wdata;
  logic [63:0]   r_valM;
  logic          r_err;

  logic          w_rd;
  logic          w_wr;
  logic [63:0]   w_addr;
  logic          w_in_range;
  logic          w_aok;
  logic          w_memop;

  // Classify the instruction and pick the address source.
  always_comb begin
    w_rd   = 1'b0;
    w_wr   = 1'b0;
    w_addr = i_M_valE;
    case (i_M_icode)
      4'h5:    w_rd = 1'b1;
      4'hB: begin
        w_rd   = 1'b1;
        w_addr = i_M_valA;
      end
      4'h9: begin
        w_rd   = 1'b1;
        w_addr = i_M_valA;
      end
      4'h4:    w_wr = 1'b1;
      4'hA:    w_wr = 1'b1;
      4'h8:    w_wr = 1'b1;
      default: begin
        w_rd = 1'b0;
        w_wr = 1'b0;
      end
    endcase
  end

  // Comparing against MEM_BYTES-8 avoids the wrap that addr+8 would have near 2^64.
  assign w_in_range = (w_addr <= MAX_ADDR);
  assign w_aok      = (i_M_stat == STAT_AOK);
  assign w_memop    = (w_rd | w_wr) & w_aok & w_in_range;

  // Access sequencer: issues the request, waits for ack or timeout, holds the result for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= 64'd0;
      r_wdata <= 64'd0;
      r_valM  <= 64'd0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_memop) begin
            r_state <= S_BUSY;
            r_req   <= 1'b1;
            r_we    <= w_wr;
            r_addr  <= w_addr;
            r_wdata <= i_M_valA;
            r_cnt   <= CW'(1);
            r_valM  <= 64'd0;
            r_err   <= 1'b0;
          end
        end
        S_BUSY: begin
          // An ack arriving in the timeout cycle still completes the access normally.
          if (dmem.ack) begin
            r_state <= S_DONE;
            r_req   <= 1'b0;
            r_valM  <= r_we ? 64'd0 : dmem.rdata;
            r_err   <= dmem.err;
          end else if (r_cnt == CW'(TIMEOUT)) begin
            r_state <= S_DONE;
            r_req   <= 1'b0;
            r_valM  <= 64'd0;
            r_err   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign dmem.req   = r_req;
  assign dmem.we    = r_we;
  assign dmem.addr  = r_addr;
  assign dmem.wdata = r_wdata;

  assign o_m_icode = i_M_icode;
  assign o_m_valE  = i_M_valE;
  assign o_m_dstE  = i_M_dstE;
  assign o_m_dstM  = i_M_dstM;

  // Stage status, loaded value and stall towards pipeline control and W.
  always_comb begin
    o_m_stall = 1'b0;
    o_m_stat  = i_M_stat;
    o_m_valM  = 64'd0;
    case (r_state)
      S_IDLE: begin
        if (w_memop) begin
          o_m_stall = 1'b1;
        end else if ((w_rd | w_wr) & w_aok) begin
          o_m_stat = STAT_ADR;
        end else begin
          o_m_stat = i_M_stat;
        end
      end
      S_BUSY: o_m_stall = 1'b1;
      S_DONE: begin
        o_m_valM = r_valM;
        o_m_stat = r_err ? STAT_ADR : STAT_AOK;
      end
      default: o_m_stall = 1'b0;
    endcase
    if (!rst_n) begin
      o_m_stall = 1'b0;
    end else begin
      o_m_stall = o_m_stall;
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// Directed scoreboard bench for mem_stage: expected results are queued at issue and compared at completion.
module tb_mem_stage;
  localparam int unsigned MEM_BYTES = 8192;
  localparam int unsigned TIMEOUT   = 16;

  typedef struct {
    logic [63:0] valM;
    logic [1:0]  stat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  M_stat;
  logic [3:0]  M_icode;
  logic [63:0] M_valE;
  logic [63:0] M_valA;
  logic [3:0]  M_dstE;
  logic [3:0]  M_dstM;
  logic        m_stall;
  logic [1:0]  m_stat;
  logic [3:0]  m_icode;
  logic [63:0] m_valE;
  logic [63:0] m_valM;
  logic [3:0]  m_dstE;
  logic [3:0]  m_dstM;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  dmem_if u_if ();

  mem_stage #(.MEM_BYTES(MEM_BYTES), .TIMEOUT(TIMEOUT)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_M_stat (M_stat),
    .i_M_icode(M_icode),
    .i_M_valE (M_valE),
    .i_M_valA (M_valA),
    .i_M_dstE (M_dstE),
    .i_M_dstM (M_dstM),
    .dmem     (u_if),
    .o_m_stall(m_stall),
    .o_m_stat (m_stat),
    .o_m_icode(m_icode),
    .o_m_valE (m_valE),
    .o_m_valM (m_valM),
    .o_m_dstE (m_dstE),
    .o_m_dstM (m_dstM)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] stat, input logic [3:0] icode,
                       input logic [63:0] valE, input logic [63:0] valA);
    M_stat  = stat;
    M_icode = icode;
    M_valE  = valE;
    M_valA  = valA;
  endtask

  // One memory access: ack_at is the BUSY cycle (1-based) carrying the ack, 0 means never.
  task automatic mem_op(input string tag, input logic [3:0] icode, input logic [63:0] valE,
                        input logic [63:0] valA, input int ack_at, input logic [63:0] rdata,
                        input logic err, input logic [63:0] exp_addr, input logic exp_we,
                        input logic [63:0] exp_wdata, input int exp_stall,
                        input logic [63:0] exp_valM, input logic [1:0] exp_stat);
    int   stall_cnt;
    int   busy;
    bit   done;
    exp_t e;
    sb_q.push_back('{exp_valM, exp_stat});
    @(posedge clk); #1;
    drive(2'd0, icode, valE, valA);
    u_if.ack  = 1'b0;
    stall_cnt = 0;
    busy      = 0;
    done      = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!m_stall) begin
        done = 1'b1;
        break;
      end
      stall_cnt++;
      @(posedge clk); #1;
      busy++;
      u_if.ack   = (busy == ack_at);
      u_if.rdata = rdata;
      u_if.err   = err;
      if (busy == 1) begin
        chk({tag, "_req"}, 64'(u_if.req), 64'd1);
        chk({tag, "_addr"}, u_if.addr, exp_addr);
        chk({tag, "_we"}, 64'(u_if.we), 64'(exp_we));
        if (exp_we) chk({tag, "_wdata"}, u_if.wdata, exp_wdata);
      end
    end
    u_if.ack = 1'b0;
    chk({tag, "_completed"}, 64'(done), 64'd1);
    chk({tag, "_stall_cycles"}, 64'(stall_cnt), 64'(exp_stall));
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk({tag, "_valM"}, m_valM, e.valM);
      chk({tag, "_stat"}, 64'(m_stat), 64'(e.stat));
    end else begin
      chk({tag, "_scoreboard_empty"}, 64'(sb_q.size()), 64'd1);
    end
    chk({tag, "_req_done"}, 64'(u_if.req), 64'd0);
    drive(2'd0, 4'h1, 64'd0, 64'd0);
  endtask

  // No-access step: the op must pass through (or flag ADR) without stalling or requesting.
  task automatic no_op(input string tag, input logic [1:0] stat, input logic [3:0] icode,
                       input logic [63:0] valE, input logic [63:0] valA, input logic [1:0] exp_stat);
    exp_t e;
    sb_q.push_back('{64'd0, exp_stat});
    @(posedge clk); #1;
    drive(stat, icode, valE, valA);
    @(negedge clk);
    e = sb_q.pop_front();
    chk({tag, "_stall"}, 64'(m_stall), 64'd0);
    chk({tag, "_stat"}, 64'(m_stat), 64'(e.stat));
    chk({tag, "_valM"}, m_valM, e.valM);
    chk({tag, "_valE"}, m_valE, valE);
    @(posedge clk); #1;
    chk({tag, "_noreq"}, 64'(u_if.req), 64'd0);
  endtask

  initial begin
    rst_n      = 1'b0;
    u_if.ack   = 1'b0;
    u_if.err   = 1'b0;
    u_if.rdata = 64'd0;
    drive(2'd0, 4'h5, 64'h100, 64'd0);
    M_dstE = 4'hF;
    M_dstM = 4'h3;
    #2;
    chk("rst_stall", 64'(m_stall), 64'd0);
    chk("rst_req", 64'(u_if.req), 64'd0);
    chk("rst_addr", u_if.addr, 64'd0);
    chk("rst_dstM", 64'(m_dstM), 64'h3);
    drive(2'd0, 4'h1, 64'd0, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    mem_op("mrmovq", 4'h5, 64'h100, 64'h0, 3, 64'hDEAD, 1'b0,
           64'h100, 1'b0, 64'h0, 4, 64'hDEAD, 2'd0);
    mem_op("pushq", 4'hA, 64'h1F8, 64'h55, 1, 64'hFFFF, 1'b0,
           64'h1F8, 1'b1, 64'h55, 2, 64'h0, 2'd0);
    mem_op("ret", 4'h9, 64'h200, 64'h1F0, 2, 64'h4242, 1'b0,
           64'h1F0, 1'b0, 64'h0, 3, 64'h4242, 2'd0);
    mem_op("popq", 4'hB, 64'h208, 64'h300, 1, 64'h77, 1'b0,
           64'h300, 1'b0, 64'h0, 2, 64'h77, 2'd0);
    mem_op("call", 4'h8, 64'h3F0, 64'h123, 1, 64'h0, 1'b0,
           64'h3F0, 1'b1, 64'h123, 2, 64'h0, 2'd0);

    no_op("range_hi", 2'd0, 4'h4, 64'(MEM_BYTES - 7), 64'h9, 2'd2);
    no_op("range_max", 2'd0, 4'h5, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 2'd2);
    mem_op("range_edge", 4'h4, 64'(MEM_BYTES - 8), 64'hAB, 1, 64'h0, 1'b0,
           64'(MEM_BYTES - 8), 1'b1, 64'hAB, 2, 64'h0, 2'd0);

    mem_op("timeout", 4'h5, 64'h40, 64'h0, 0, 64'h5A5A, 1'b0,
           64'h40, 1'b0, 64'h0, TIMEOUT + 1, 64'h0, 2'd2);
    mem_op("ack_at_limit", 4'h5, 64'h48, 64'h0, TIMEOUT, 64'h1234, 1'b0,
           64'h48, 1'b0, 64'h0, TIMEOUT + 1, 64'h1234, 2'd0);
    mem_op("err", 4'h5, 64'h50, 64'h0, 2, 64'h99, 1'b1,
           64'h50, 1'b0, 64'h0, 3, 64'h99, 2'd2);

    no_op("hlt", 2'd1, 4'h4, 64'h10, 64'h1, 2'd1);
    no_op("ins", 2'd3, 4'h5, 64'h20, 64'h0, 2'd3);
    no_op("opq", 2'd0, 4'h6, 64'hCAFE, 64'h0, 2'd0);

    // Stray ack while idle must not produce a result.
    @(posedge clk); #1;
    u_if.ack   = 1'b1;
    u_if.rdata = 64'hBAD;
    @(posedge clk); #1;
    u_if.ack = 1'b0;
    @(negedge clk);
    chk("stray_ack_stall", 64'(m_stall), 64'd0);
    chk("stray_ack_valM", m_valM, 64'd0);
    chk("stray_ack_req", 64'(u_if.req), 64'd0);

    // Reset in the middle of an access.
    @(posedge clk); #1;
    drive(2'd0, 4'h4, 64'h80, 64'h11);
    @(posedge clk); #1;
    chk("midrst_req_before", 64'(u_if.req), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_req", 64'(u_if.req), 64'd0);
    chk("midrst_stall", 64'(m_stall), 64'd0);
    chk("midrst_addr", u_if.addr, 64'd0);
    chk("midrst_valE", m_valE, 64'h80);
    drive(2'd0, 4'h1, 64'd0, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_stall", 64'(m_stall), 64'd0);
    chk("post_rst_req", 64'(u_if.req), 64'd0);

    mem_op("after_rst", 4'h5, 64'h88, 64'h0, 1, 64'h6161, 1'b0,
           64'h88, 1'b0, 64'h0, 2, 64'h6161, 2'd0);
    chk("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
